boot_loader: RTL and testbench

Boot sequencer between the UART byte receiver, the instruction ROM write port and the CPU reset. After board reset it holds the CPU in reset and receives a framed program image over UART. It writes the image into ROM word by word, verifies an XOR checksum, then releases the CPU. On any framing or checksum failure the CPU stays in reset and the error flag is raised.

---
 rtl/lib_cpu.sv | 24 ++
 rtl/boot_word_packer.sv | 54 +++++
 rtl/boot_loader.sv | 158 +++++++++++++++
 tb/tb_boot_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lib_cpu.sv
`default_nettype none
// ============================================================================
// Module   : lib_cpu (package)
// Purpose  : Shared CPU-subsystem definitions: boot sequencer state encoding
//            and the boot frame magic byte.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lib_cpu;

  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    LEN_LO     = 3'd1,
    LEN_HI     = 3'd2,
    DATA       = 3'd3,
    CSUM       = 3'd4,
    RUN        = 3'd5,
    ERROR      = 3'd6
  } BOOT_STATE;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

endpackage : lib_cpu
`default_nettype wire

// File: rtl/boot_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : boot_word_packer
// Purpose  : Packs a little-endian byte stream into 32-bit words. The first
//            byte of a word lands in bits [7:0].
// Ports    : clk, reset     - clock, synchronous active-high reset
//            byte_valid     - byte_data carries a byte this cycle
//            byte_data[7:0] - incoming byte
//            clear          - restart at byte 0 of a new word
//            byte_last      - (comb) current byte completes a word
//            word[31:0]     - assembly register (valid while word_done)
//            word_done      - registered one-cycle pulse after the 4th byte
// Revision : 1.0 - initial release
// ============================================================================
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        clear,
  output logic        byte_last,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic        r_done;

  // Lets the owner of the FSM act on the 4th byte in the same cycle it arrives.
  assign byte_last = byte_valid && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_idx <= 2'd0;
      end else if (byte_valid) begin
        r_word[8*r_idx +: 8] <= byte_data;
        r_idx                <= r_idx + 2'd1;
        r_done               <= (r_idx == 2'd3);
      end
    end
  end

  assign word      = r_word;
  assign word_done = r_done;

endmodule : boot_word_packer
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Purpose  : Boot sequencer. Holds the CPU in reset, receives a framed image
//            (A5, LEN_LO, LEN_HI, N*4 data bytes, XOR CSUM) over UART, writes
//            it to ROM word by word and releases the CPU on a good checksum.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            rx_valid, rx_data   - received UART byte strobe and data
//            rom_we, rom_addr,
//            rom_wdata           - ROM write port (one cycle per word)
//            cpu_reset           - CPU reset, low only once the image is in
//            loaded, error       - image accepted / frame rejected (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader
  import lib_cpu::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  cpu_reset,
  output logic                  loaded,
  output logic                  error
);

  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]     c_depth   = 17'(2 ** ADDR_WIDTH);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

  BOOT_STATE r_state, w_next;

  logic [7:0]            r_len_lo;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [7:0]            r_csum;
  logic [c_cnt_w-1:0]    r_idle;
  logic                  r_cpu_reset;
  logic                  r_loaded;
  logic                  r_error;

  logic        w_byte_last;
  logic        w_timed;
  logic        w_timeout;
  logic [15:0] w_len;
  logic        w_last_word;

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (rx_valid && (r_state == DATA)),
    .byte_data  (rx_data),
    .clear      (r_state == WAIT_MAGIC),
    .byte_last  (w_byte_last),
    .word       (rom_wdata),
    .word_done  (rom_we)
  );

  assign w_timed = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                   (r_state == DATA)   || (r_state == CSUM);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout = w_timed && !rx_valid && (r_idle == c_timeout);
  assign w_len     = {rx_data, r_len_lo};
  // Compared at 17 bits so N == 2**ADDR_WIDTH never needs an address wrap.
  assign w_last_word = ({{(17-ADDR_WIDTH){1'b0}}, r_waddr} == ({1'b0, r_len} - 17'd1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_MAGIC;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_MAGIC: if (rx_valid && (rx_data == BOOT_MAGIC)) w_next = LEN_LO;
      LEN_LO: begin
        if (rx_valid)       w_next = LEN_HI;
        else if (w_timeout) w_next = WAIT_MAGIC;
      end
      LEN_HI: begin
        if (rx_valid) begin
          if ({1'b0, w_len} > c_depth) w_next = ERROR;
          else if (w_len == 16'd0)     w_next = CSUM;
          else                         w_next = DATA;
        end else if (w_timeout) begin
          w_next = WAIT_MAGIC;
        end
      end
      DATA: begin
        if (w_byte_last && w_last_word) w_next = CSUM;
        else if (w_timeout)             w_next = WAIT_MAGIC;
      end
      CSUM: begin
        if (rx_valid)       w_next = (rx_data == r_csum) ? RUN : ERROR;
        else if (w_timeout) w_next = WAIT_MAGIC;
      end
      RUN:     w_next = RUN;
      ERROR:   w_next = ERROR;
      default: w_next = WAIT_MAGIC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_lo    <= 8'd0;
      r_len       <= 16'd0;
      r_waddr     <= '0;
      r_rom_addr  <= '0;
      r_csum      <= 8'd0;
      r_idle      <= '0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Registered from the next state so release/error appear the cycle
      // after the deciding byte.
      r_cpu_reset <= (w_next != RUN);
      r_loaded    <= (w_next == RUN);
      r_error     <= (w_next == ERROR);

      if (!w_timed || rx_valid || w_timeout) r_idle <= '0;
      else                                   r_idle <= r_idle + c_cnt_w'(1);

      case (r_state)
        WAIT_MAGIC: begin
          r_waddr <= '0;
          r_csum  <= 8'd0;
        end
        LEN_LO: if (rx_valid) r_len_lo <= rx_data;
        LEN_HI: if (rx_valid) r_len    <= w_len;
        DATA: begin
          if (rx_valid) r_csum <= r_csum ^ rx_data;
          // rom_addr is captured separately so it holds through and after
          // the write while the working address moves on.
          if (w_byte_last) begin
            r_rom_addr <= r_waddr;
            r_waddr    <= r_waddr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_rom_addr;
  assign cpu_reset = r_cpu_reset;
  assign loaded    = r_loaded;
  assign error     = r_error;

endmodule : boot_loader
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader
// Purpose  : Self-checking bench for boot_loader (ADDR_WIDTH=4, short
//            timeout). Each table row is one clock cycle of inputs plus the
//            outputs expected just after that clock edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

  localparam int c_aw = 4;
  localparam int c_to = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rom_we;
  logic [c_aw-1:0] rom_addr;
  logic [31:0] rom_wdata;
  logic        cpu_reset;
  logic        loaded;
  logic        error;

  boot_loader #(.ADDR_WIDTH(c_aw), .TIMEOUT_CYCLES(c_to)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            v;
    logic [7:0]      d;
    logic            we;
    logic            chk;   // also compare rom_addr / rom_wdata
    logic [c_aw-1:0] addr;
    logic [31:0]     wdata;
    logic            cr;
    logic            ld;
    logic            er;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic we, input logic chk, input logic [c_aw-1:0] a,
                     input logic [31:0] w, input logic cr, input logic ld,
                     input logic er);
    vec_t t;
    t = '{rst, v, d, we, chk, a, w, cr, ld, er};
    tbl.push_back(t);
  endtask

  task automatic add_rst();
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, '0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic add_b(input logic [7:0] d, input logic cr, input logic ld, input logic er);
    add(1'b0, 1'b1, d, 1'b0, 1'b0, '0, 32'h0, cr, ld, er);
  endtask

  task automatic add_idle(input int n, input logic cr, input logic ld, input logic er);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0, 32'h0, cr, ld, er);
  endtask

  task automatic add_word(input logic [c_aw-1:0] a, input logic [31:0] w);
    add_b(w[7:0], 1'b1, 1'b0, 1'b0);
    add_b(w[15:8], 1'b1, 1'b0, 1'b0);
    add_b(w[23:16], 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, w[31:24], 1'b1, 1'b1, a, w, 1'b1, 1'b0, 1'b0);
  endtask

  // Two-word frame after the magic byte; good checksum is 0x2A.
  task automatic add_body(input logic [7:0] cs);
    add_b(8'h02, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_word(4'd0, 32'h12345678);
    add_word(4'd1, 32'hDEADBEEF);
    if (cs == 8'h2A) add_b(cs, 1'b0, 1'b1, 1'b0);
    else             add_b(cs, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic add_frame(input logic [7:0] cs);
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_body(cs);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] w;

    // Scenario 1: good two-word image, then RUN ignores further bytes.
    add_rst();
    add_frame(8'h2A);
    add_idle(2, 1'b0, 1'b1, 1'b0);
    add_b(8'hA5, 1'b0, 1'b1, 1'b0);
    add_b(8'h00, 1'b0, 1'b1, 1'b0);

    // Scenario 2: bad checksum, ERROR is terminal.
    add_rst();
    add_frame(8'h2B);
    add_b(8'hA5, 1'b1, 1'b0, 1'b1);
    add_b(8'h00, 1'b1, 1'b0, 1'b1);
    add_b(8'h00, 1'b1, 1'b0, 1'b1);
    add_b(8'h00, 1'b1, 1'b0, 1'b1);

    // Scenario 3: garbage before magic, then an empty image.
    add_rst();
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_b(8'hFF, 1'b1, 1'b0, 1'b0);
    add_b(8'h5A, 1'b1, 1'b0, 1'b0);
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b0, 1'b1, 1'b0);

    // Scenario 4: timeout mid-word, silent restart, reload.
    add_rst();
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_b(8'h02, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_b(8'h78, 1'b1, 1'b0, 1'b0);
    add_idle(c_to + 1, 1'b1, 1'b0, 1'b0);
    add_frame(8'h2A);

    // Scenario 4b: byte arriving exactly when the counter hits the limit.
    add_rst();
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_idle(c_to, 1'b1, 1'b0, 1'b0);
    add_body(8'h2A);

    // Scenario 5: oversize count (17 > 16) rejected.
    add_rst();
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_b(8'h11, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b1);
    add_b(8'h78, 1'b1, 1'b0, 1'b1);

    // Scenario 5b: full-depth image of 16 words.
    add_rst();
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_b(8'h10, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    cs = 8'h00;
    for (int k = 0; k < 16; k++) begin
      w  = {8'(k * 3 + 1), 8'(k ^ 8'h5A), 8'hDE, 8'(k)};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      add_word(c_aw'(k), w);
    end
    add_b(cs, 1'b0, 1'b1, 1'b0);

    // Scenario 6: reset after 5 data bytes, then a full reload.
    add_rst();
    add_b(8'hA5, 1'b1, 1'b0, 1'b0);
    add_b(8'h02, 1'b1, 1'b0, 1'b0);
    add_b(8'h00, 1'b1, 1'b0, 1'b0);
    add_word(4'd0, 32'h12345678);
    add_b(8'hEF, 1'b1, 1'b0, 1'b0);
    add_rst();
    add_frame(8'h2A);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset    = tbl[i].rst;
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      @(posedge clk);
      #1;
      n_total++;
      if ({rom_we, cpu_reset, loaded, error} === {tbl[i].we, tbl[i].cr, tbl[i].ld, tbl[i].er})
        n_pass++;
      else
        $display("FAIL row %0d flags we/cpu_reset/loaded/error: got %b%b%b%b want %b%b%b%b",
                 i, rom_we, cpu_reset, loaded, error,
                 tbl[i].we, tbl[i].cr, tbl[i].ld, tbl[i].er);
      if (tbl[i].chk) begin
        n_total++;
        if (rom_addr === tbl[i].addr && rom_wdata === tbl[i].wdata)
          n_pass++;
        else
          $display("FAIL row %0d rom addr/wdata: got %0d/%h want %0d/%h",
                   i, rom_addr, rom_wdata, tbl[i].addr, tbl[i].wdata);
      end
    end

    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_boot_loader
`default_nettype wire
